// File: rtl/kuruvi_pkg.sv
// Kuruvi nested loop counter: shared sizing defaults
// and packed-bus slice helper.
package kuruvi_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_LOOPS = 3;

  // Low bit of loop k's field in a packed NUM_LOOPS*WIDTH bus.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/loop_stage.sv
// One loop of the nest: index and limit registers,
// carry ripple and registered wrap pulse.
module loop_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LD_LIM,
  input  logic [WIDTH-1:0] lim_in,
  input  logic             LD_IDX,
  input  logic [WIDTH-1:0] idx_in,
  input  logic             carry_in,
  output logic             carry_out,
  output logic [WIDTH-1:0] idx_out,
  output logic             LAST,
  output logic             WRAP
);

  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_lim;
  logic             r_wrap;
  logic             w_last;

  // An index above its limit also counts as last, so it wraps next.
  assign w_last    = (r_idx >= r_lim);
  assign carry_out = carry_in & w_last;
  assign idx_out   = r_idx;
  assign LAST      = w_last;
  assign WRAP      = r_wrap;

  // Limit register; loads alongside any other command.
  always_ff @(posedge clock) begin
    if (RST)
      r_lim <= '1;
    else if (LD_LIM)
      r_lim <= lim_in;
  end

  // Index register: clear, then load, then step.
  always_ff @(posedge clock) begin
    if (RST || CLR)
      r_idx <= '0;
    else if (LD_IDX)
      r_idx <= idx_in;
    else if (carry_in)
      r_idx <= w_last ? '0 : r_idx + WIDTH'(1);
  end

  // Wrap pulse lasts one cycle after the wrapping edge.
  always_ff @(posedge clock) begin
    if (RST)
      r_wrap <= 1'b0;
    else
      r_wrap <= carry_out;
  end

endmodule

// File: rtl/nested_loop_counter.sv
// Chained loop-index bank for the matrix-multiply datapath;
// one STEP advances the innermost loop and ripples outward.
module nested_loop_counter
  import kuruvi_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_LOOPS = DEF_NUM_LOOPS
) (
  input  logic                       clock,
  input  logic                       RST,
  input  logic                       CLR,
  input  logic                       LD_LIM,
  input  logic [NUM_LOOPS*WIDTH-1:0] lim_in,
  input  logic [NUM_LOOPS-1:0]       LD_IDX,
  input  logic [NUM_LOOPS*WIDTH-1:0] idx_in,
  input  logic                       STEP,
  output logic [NUM_LOOPS*WIDTH-1:0] idx_out,
  output logic [NUM_LOOPS-1:0]       LAST,
  output logic [NUM_LOOPS-1:0]       WRAP,
  output logic                       DONE
);

  logic [NUM_LOOPS:0] w_carry;
  logic               r_done;

  // STEP is accepted only when no higher command is present.
  assign w_carry[0] = STEP & ~r_done & ~CLR & ~|LD_IDX;
  assign DONE       = r_done;

  for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_loop
    loop_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock     (clock),
      .RST       (RST),
      .CLR       (CLR),
      .LD_LIM    (LD_LIM),
      .lim_in    (lim_in[slice_lo(k, WIDTH) +: WIDTH]),
      .LD_IDX    (LD_IDX[k]),
      .idx_in    (idx_in[slice_lo(k, WIDTH) +: WIDTH]),
      .carry_in  (w_carry[k]),
      .carry_out (w_carry[k+1]),
      .idx_out   (idx_out[slice_lo(k, WIDTH) +: WIDTH]),
      .LAST      (LAST[k]),
      .WRAP      (WRAP[k])
    );
  end

  // Sticky completion: set when the outermost loop wraps.
  always_ff @(posedge clock) begin
    if (RST || CLR)
      r_done <= 1'b0;
    else if (w_carry[NUM_LOOPS])
      r_done <= 1'b1;
  end

endmodule
